// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the result scoreboard.
// Stat fields are STAT_FIELD_W wide; TS_W + CNT_W must not exceed it.
package scoreboard_pkg;

  localparam int HIST_BINS    = 8;
  localparam int STAT_FIELD_W = 32;

  typedef logic [STAT_FIELD_W-1:0] stat_field_t;

  typedef struct packed {
    stat_field_t err;
    stat_field_t unexp;
    stat_field_t drop;
    stat_field_t samples;
    stat_field_t min;
    stat_field_t max;
    stat_field_t sum;
  } stat_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Add and clamp to the all-ones value of a w-bit field.
  function automatic stat_field_t sat_add(input stat_field_t a, input stat_field_t b, input int w);
    logic [STAT_FIELD_W:0] s;
    logic [STAT_FIELD_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ({{STAT_FIELD_W{1'b0}}, 1'b1} << w) - 1'b1;
    return (s > lim) ? lim[STAT_FIELD_W-1:0] : s[STAT_FIELD_W-1:0];
  endfunction

  // floor(log2(lat)) for lat < 128 (0 and 1 share bin 0), bin 7 otherwise.
  function automatic logic [2:0] hist_bin(input stat_field_t lat);
    logic [2:0] b;
    b = 3'd0;
    if (lat >= 128) begin
      b = 3'd7;
    end else begin
      for (int k = 1; k < 7; k++) begin
        if (lat[k]) b = 3'(k);
      end
    end
    return b;
  endfunction

endpackage

// File: rtl/sb_sync_fifo.sv
// Synchronous FIFO holding {expected, issue timestamp} entries for one channel.
// Zero-latency head (pop_data shows the head); push ignored when full, pop ignored when empty.
module sb_sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/result_scoreboard.sv
// Multi-channel in-order result checker with latency statistics; rd_* and any_error registered (1 cycle).
// Requests back-pressured per channel via req_ready (full drops are counted); responses always accepted.
// Optional latency histogram and rd_hist port under RESULT_SCOREBOARD_HIST_EN.
module result_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ch_w(NUM_CH)-1:0]    req_ch,
  input  logic [DATA_W-1:0]          req_expected,
  input  logic                       rsp_valid,
  input  logic [ch_w(NUM_CH)-1:0]    rsp_ch,
  input  logic [DATA_W-1:0]          rsp_data,
  input  logic                       stat_clr,
  input  logic [ch_w(NUM_CH)-1:0]    rd_ch,
  output logic [CNT_W-1:0]           rd_err,
  output logic [CNT_W-1:0]           rd_unexp,
  output logic [CNT_W-1:0]           rd_drop,
  output logic [CNT_W-1:0]           rd_samples,
  output logic [TS_W-1:0]            rd_min,
  output logic [TS_W-1:0]            rd_max,
  output logic [TS_W+CNT_W-1:0]      rd_sum,
`ifdef RESULT_SCOREBOARD_HIST_EN
  output logic [HIST_BINS*CNT_W-1:0] rd_hist,
`endif
  output logic                       any_error
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam int EW   = DATA_W + TS_W;
  localparam stat_field_t MIN_RST = stat_field_t'((64'd1 << TS_W) - 64'd1);
  localparam stat_t STAT_RST = '{err: '0, unexp: '0, drop: '0, samples: '0,
                                 min: MIN_RST, max: '0, sum: '0};

  logic [TS_W-1:0]   ts;
  logic [NUM_CH-1:0] fifo_push;
  logic [NUM_CH-1:0] fifo_pop;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [EW-1:0]     fifo_head [NUM_CH];
  stat_t             st_q [NUM_CH];
  stat_t             st_d [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign fifo_push[c] = req_valid && (req_ch == CH_W'(c)) && !fifo_full[c];
    assign fifo_pop[c]  = rsp_valid && (rsp_ch == CH_W'(c)) && !fifo_empty[c];

    sb_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[c]),
      .push_data ({req_expected, ts}),
      .pop       (fifo_pop[c]),
      .pop_data  (fifo_head[c]),
      .full      (fifo_full[c]),
      .empty     (fifo_empty[c])
    );
  end

  always_comb begin
    req_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (req_ch == CH_W'(c)) req_ready = !fifo_full[c];
    end
  end

`ifdef RESULT_SCOREBOARD_HIST_EN
  logic [HIST_BINS*CNT_W-1:0] hist_q [NUM_CH];
  logic [HIST_BINS*CNT_W-1:0] hist_d [NUM_CH];
`endif

  // Fullness/emptiness sampled before this cycle's push/pop, so no bypass either way.
  always_comb begin : stat_next
    logic [DATA_W-1:0] head_exp;
    logic [TS_W-1:0]   head_ts;
    logic [TS_W-1:0]   lat;
    stat_field_t       lat_ext;
`ifdef RESULT_SCOREBOARD_HIST_EN
    logic [2:0]        bin;
    stat_field_t       bin_cnt;
    bin     = '0;
    bin_cnt = '0;
`endif
    head_exp = '0;
    head_ts  = '0;
    lat      = '0;
    lat_ext  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c] = st_q[c];
`ifdef RESULT_SCOREBOARD_HIST_EN
      hist_d[c] = hist_q[c];
`endif
      {head_exp, head_ts} = fifo_head[c];
      lat     = ts - head_ts;
      lat_ext = '0;
      lat_ext[TS_W-1:0] = lat;

      if (req_valid && (req_ch == CH_W'(c)) && fifo_full[c])
        st_d[c].drop = sat_add(st_q[c].drop, 32'd1, CNT_W);

      if (rsp_valid && (rsp_ch == CH_W'(c))) begin
        if (fifo_empty[c]) begin
          st_d[c].unexp = sat_add(st_q[c].unexp, 32'd1, CNT_W);
        end else begin
          if (rsp_data !== head_exp)
            st_d[c].err = sat_add(st_q[c].err, 32'd1, CNT_W);
          st_d[c].samples = sat_add(st_q[c].samples, 32'd1, CNT_W);
          st_d[c].sum     = sat_add(st_q[c].sum, lat_ext, TS_W + CNT_W);
          if (lat_ext < st_q[c].min) st_d[c].min = lat_ext;
          if (lat_ext > st_q[c].max) st_d[c].max = lat_ext;
`ifdef RESULT_SCOREBOARD_HIST_EN
          bin     = hist_bin(lat_ext);
          bin_cnt = '0;
          bin_cnt[CNT_W-1:0] = hist_q[c][int'(bin)*CNT_W +: CNT_W];
          bin_cnt = sat_add(bin_cnt, 32'd1, CNT_W);
          hist_d[c][int'(bin)*CNT_W +: CNT_W] = bin_cnt[CNT_W-1:0];
`endif
        end
      end

      if (stat_clr) begin
        st_d[c] = STAT_RST;
`ifdef RESULT_SCOREBOARD_HIST_EN
        hist_d[c] = '0;
`endif
      end
    end
  end

  logic [CNT_W-1:0]      sel_err;
  logic [CNT_W-1:0]      sel_unexp;
  logic [CNT_W-1:0]      sel_drop;
  logic [CNT_W-1:0]      sel_samples;
  logic [TS_W-1:0]       sel_min;
  logic [TS_W-1:0]       sel_max;
  logic [TS_W+CNT_W-1:0] sel_sum;
  logic                  any_nz;
`ifdef RESULT_SCOREBOARD_HIST_EN
  logic [HIST_BINS*CNT_W-1:0] sel_hist;
`endif

  always_comb begin
    sel_err     = '0;
    sel_unexp   = '0;
    sel_drop    = '0;
    sel_samples = '0;
    sel_min     = '0;
    sel_max     = '0;
    sel_sum     = '0;
    any_nz      = 1'b0;
`ifdef RESULT_SCOREBOARD_HIST_EN
    sel_hist    = '0;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_ch == CH_W'(c)) begin
        sel_err     = st_q[c].err[CNT_W-1:0];
        sel_unexp   = st_q[c].unexp[CNT_W-1:0];
        sel_drop    = st_q[c].drop[CNT_W-1:0];
        sel_samples = st_q[c].samples[CNT_W-1:0];
        sel_min     = st_q[c].min[TS_W-1:0];
        sel_max     = st_q[c].max[TS_W-1:0];
        sel_sum     = st_q[c].sum[TS_W+CNT_W-1:0];
`ifdef RESULT_SCOREBOARD_HIST_EN
        sel_hist    = hist_q[c];
`endif
      end
      if ((st_q[c].err != '0) || (st_q[c].unexp != '0) || (st_q[c].drop != '0))
        any_nz = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts         <= '0;
      rd_err     <= '0;
      rd_unexp   <= '0;
      rd_drop    <= '0;
      rd_samples <= '0;
      rd_min     <= '0;
      rd_max     <= '0;
      rd_sum     <= '0;
      any_error  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) st_q[c] <= STAT_RST;
`ifdef RESULT_SCOREBOARD_HIST_EN
      rd_hist <= '0;
      for (int c = 0; c < NUM_CH; c++) hist_q[c] <= '0;
`endif
    end else begin
      ts         <= ts + 1'b1;
      rd_err     <= sel_err;
      rd_unexp   <= sel_unexp;
      rd_drop    <= sel_drop;
      rd_samples <= sel_samples;
      rd_min     <= sel_min;
      rd_max     <= sel_max;
      rd_sum     <= sel_sum;
      any_error  <= stat_clr ? 1'b0 : (any_error | any_nz);
      for (int c = 0; c < NUM_CH; c++) st_q[c] <= st_d[c];
`ifdef RESULT_SCOREBOARD_HIST_EN
      rd_hist <= sel_hist;
      for (int c = 0; c < NUM_CH; c++) hist_q[c] <= hist_d[c];
`endif
    end
  end

endmodule

// File: tb/tb_result_scoreboard.sv
// Directed + randomized bench for result_scoreboard (TS_W=8 to exercise timestamp wrap).
module tb_result_scoreboard;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int TSW   = 8;
  localparam int CNTW  = 16;
  localparam int CNT_MAX = 65535;
  localparam longint SUM_MAX = 64'd16777215;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_ch;
  logic [31:0] req_expected;
  logic        rsp_valid;
  logic [1:0]  rsp_ch;
  logic [31:0] rsp_data;
  logic        stat_clr;
  logic [1:0]  rd_ch;
  logic [CNTW-1:0] rd_err, rd_unexp, rd_drop, rd_samples;
  logic [TSW-1:0]  rd_min, rd_max;
  logic [TSW+CNTW-1:0] rd_sum;
  logic        any_error;
`ifdef RESULT_SCOREBOARD_HIST_EN
  logic [8*CNTW-1:0] rd_hist;
`endif

  result_scoreboard #(
    .NUM_CH (NCH), .DATA_W (32), .DEPTH (DEPTH), .TS_W (TSW), .CNT_W (CNTW)
  ) dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready), .req_ch (req_ch), .req_expected (req_expected),
    .rsp_valid (rsp_valid), .rsp_ch (rsp_ch), .rsp_data (rsp_data),
    .stat_clr (stat_clr), .rd_ch (rd_ch),
    .rd_err (rd_err), .rd_unexp (rd_unexp), .rd_drop (rd_drop), .rd_samples (rd_samples),
    .rd_min (rd_min), .rd_max (rd_max), .rd_sum (rd_sum),
`ifdef RESULT_SCOREBOARD_HIST_EN
    .rd_hist (rd_hist),
`endif
    .any_error (any_error)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: per-channel queues, plain counters, expected registered outputs.
  logic [31:0] mq_d [NCH][$];
  int          mq_t [NCH][$];
  int          m_err [NCH], m_unexp [NCH], m_drop [NCH], m_samp [NCH], m_min [NCH], m_max [NCH];
  longint      m_sum [NCH];
  int          m_ts;
  int          e_err, e_unexp, e_drop, e_samp, e_min, e_max;
  longint      e_sum;
  bit          e_any;

  function automatic int sat_cnt(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  task automatic clear_stats();
    for (int c = 0; c < NCH; c++) begin
      m_err[c] = 0; m_unexp[c] = 0; m_drop[c] = 0; m_samp[c] = 0;
      m_min[c] = 255; m_max[c] = 0; m_sum[c] = 0;
    end
  endtask

  task automatic model_reset();
    clear_stats();
    for (int c = 0; c < NCH; c++) begin
      mq_d[c].delete();
      mq_t[c].delete();
    end
    e_err = 0; e_unexp = 0; e_drop = 0; e_samp = 0; e_min = 0; e_max = 0; e_sum = 0;
    e_any = 1'b0;
    m_ts = 0;
  endtask

  task automatic model_edge();
    bit nz, rq_full, rs_empty;
    int lat;
    logic [31:0] hd;
    e_err = m_err[rd_ch]; e_unexp = m_unexp[rd_ch]; e_drop = m_drop[rd_ch];
    e_samp = m_samp[rd_ch]; e_min = m_min[rd_ch]; e_max = m_max[rd_ch]; e_sum = m_sum[rd_ch];
    nz = 1'b0;
    for (int c = 0; c < NCH; c++)
      if (m_err[c] != 0 || m_unexp[c] != 0 || m_drop[c] != 0) nz = 1'b1;
    e_any = stat_clr ? 1'b0 : (e_any | nz);
    rq_full  = (mq_d[req_ch].size() >= DEPTH);
    rs_empty = (mq_d[rsp_ch].size() == 0);
    if (rsp_valid) begin
      if (rs_empty) begin
        m_unexp[rsp_ch] = sat_cnt(m_unexp[rsp_ch]);
      end else begin
        hd  = mq_d[rsp_ch].pop_front();
        lat = (m_ts - mq_t[rsp_ch].pop_front()) & 255;
        if (rsp_data !== hd) m_err[rsp_ch] = sat_cnt(m_err[rsp_ch]);
        m_samp[rsp_ch] = sat_cnt(m_samp[rsp_ch]);
        m_sum[rsp_ch]  = (m_sum[rsp_ch] + lat > SUM_MAX) ? SUM_MAX : m_sum[rsp_ch] + lat;
        if (lat < m_min[rsp_ch]) m_min[rsp_ch] = lat;
        if (lat > m_max[rsp_ch]) m_max[rsp_ch] = lat;
      end
    end
    if (req_valid) begin
      if (rq_full) m_drop[req_ch] = sat_cnt(m_drop[req_ch]);
      else begin
        mq_d[req_ch].push_back(req_expected);
        mq_t[req_ch].push_back(m_ts);
      end
    end
    if (stat_clr) clear_stats();
    m_ts = (m_ts + 1) & 255;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0; rsp_valid = 1'b0; stat_clr = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string t);
    chk({t, ".err"},   64'(rd_err),     64'(e_err));
    chk({t, ".unexp"}, 64'(rd_unexp),   64'(e_unexp));
    chk({t, ".drop"},  64'(rd_drop),    64'(e_drop));
    chk({t, ".samp"},  64'(rd_samples), 64'(e_samp));
    chk({t, ".min"},   64'(rd_min),     64'(e_min));
    chk({t, ".max"},   64'(rd_max),     64'(e_max));
    chk({t, ".sum"},   64'(rd_sum),     64'(e_sum));
    chk({t, ".any"},   64'(any_error),  64'(e_any));
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] d);
    req_valid = 1'b1; req_ch = ch; req_expected = d;
    tick();
    idle();
  endtask

  task automatic respond(input logic [1:0] ch, input logic [31:0] d);
    rsp_valid = 1'b1; rsp_ch = ch; rsp_data = d;
    tick();
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; idle(); req_ch = '0; req_expected = '0; rsp_ch = '0; rsp_data = '0; rd_ch = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.ready", 64'(req_ready), 64'd1);
    rst = 1'b0;

    // Single match, latency 5, readout follows rd_ch after one cycle
    push(2'd0, 32'hA5A5A5A5);
    repeat (4) tick();
    rd_ch = 2'd1;
    respond(2'd0, 32'hA5A5A5A5);
    tick();
    check_all("t1_ch1");
    rd_ch = 2'd0;
    tick();
    check_all("t1");
    chk("t1.samples_k", 64'(rd_samples), 64'd1);
    chk("t1.min_k", 64'(rd_min), 64'd5);
    chk("t1.max_k", 64'(rd_max), 64'd5);
    chk("t1.sum_k", 64'(rd_sum), 64'd5);
    chk("t1.err_k", 64'(rd_err), 64'd0);

    // Equal / different / equal on ch1
    for (int i = 0; i < 3; i++) push(2'd1, 32'h1000 + i);
    for (int i = 0; i < 3; i++) respond(2'd1, (i == 1) ? 32'hDEAD : 32'h1000 + i);
    rd_ch = 2'd1;
    tick();
    check_all("t2");
    chk("t2.err_k", 64'(rd_err), 64'd1);
    chk("t2.samples_k", 64'(rd_samples), 64'd3);
    chk("t2.any_k", 64'(any_error), 64'd1);

    // Response on empty ch2 with same-cycle push: unexpected, entry kept
    rsp_valid = 1'b1; rsp_ch = 2'd2; rsp_data = 32'h2222;
    req_valid = 1'b1; req_ch = 2'd2; req_expected = 32'h2222;
    tick(); idle();
    rd_ch = 2'd2;
    tick();
    check_all("t3");
    chk("t3.unexp_k", 64'(rd_unexp), 64'd1);
    chk("t3.samples_k", 64'(rd_samples), 64'd0);
    respond(2'd2, 32'h2222);
    tick();
    chk("t3.kept_k", 64'(rd_samples), 64'd1);

    // Fill ch3, overflow, then pop+push in the same cycle still drops
    for (int i = 0; i < DEPTH; i++) push(2'd3, 32'h3000 + i);
    req_valid = 1'b1; req_ch = 2'd3; req_expected = 32'hBAD;
    #1 chk("t4.ready_full", 64'(req_ready), 64'd0);
    tick(); idle();
    req_valid = 1'b1; req_ch = 2'd3; req_expected = 32'hBAD2;
    rsp_valid = 1'b1; rsp_ch = 2'd3; rsp_data = 32'h3000;
    #1 chk("t4.ready_pop", 64'(req_ready), 64'd0);
    tick(); idle();
    rd_ch = 2'd3;
    tick();
    check_all("t4");
    chk("t4.drop_k", 64'(rd_drop), 64'd2);

    // Timestamp wrap: push at 250, respond at 4 -> latency 10
    guard = 0;
    while (m_ts != 250 && guard < 300) begin tick(); guard++; end
    push(2'd0, 32'h5555);
    guard = 0;
    while (m_ts != 4 && guard < 300) begin tick(); guard++; end
    respond(2'd0, 32'h5555);
    rd_ch = 2'd0;
    tick();
    check_all("t5");
    chk("t5.max_k", 64'(rd_max), 64'd10);
    chk("t5.sum_k", 64'(rd_sum), 64'd15);

    // stat_clr with two outstanding entries; the clear wins over a same-cycle unexpected
    push(2'd1, 32'h61);
    push(2'd1, 32'h62);
    stat_clr = 1'b1; rsp_valid = 1'b1; rsp_ch = 2'd0; rsp_data = 32'h0;
    tick(); idle();
    rd_ch = 2'd1;
    tick();
    check_all("t6_clr");
    chk("t6.min_k", 64'(rd_min), 64'd255);
    chk("t6.any_k", 64'(any_error), 64'd0);
    respond(2'd1, 32'h61);
    respond(2'd1, 32'h62);
    tick();
    check_all("t6_after");
    chk("t6.samples_k", 64'(rd_samples), 64'd2);

    // Mid-run reset empties every FIFO
    push(2'd0, 32'h71);
    push(2'd2, 32'h72);
    rst = 1'b1;
    model_reset();
    #1 check_all("t7_rst");
    chk("t7.ready", 64'(req_ready), 64'd1);
    tick();
    rst = 1'b0;
    respond(2'd3, 32'h3001);
    rd_ch = 2'd3;
    tick();
    check_all("t7");
    chk("t7.unexp_k", 64'(rd_unexp), 64'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int c;
      req_valid = ($urandom_range(0, 3) < ((i < 300) ? 3 : 2));
      req_ch = 2'($urandom_range(0, 3));
      req_expected = $urandom;
      rsp_valid = ($urandom_range(0, 3) < ((i < 300) ? 1 : 2));
      rsp_ch = 2'($urandom_range(0, 3));
      c = int'(rsp_ch);
      rsp_data = (mq_d[c].size() != 0 && $urandom_range(0, 3) != 0) ? mq_d[c][0] : $urandom;
      stat_clr = ($urandom_range(0, 79) == 0);
      rd_ch = 2'($urandom_range(0, 3));
      #1 chk("rnd.ready", 64'(req_ready), 64'(mq_d[req_ch].size() < DEPTH));
      tick();
      check_all("rnd");
    end
    idle();
    tick();
    check_all("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
